// File: rtl/deadlock_mon_pkg.sv
// Shared types and defaults for the kernel deadlock monitor blocks.
// The one-hot state encoding keeps the decode of block to a single flop bit.
`timescale 1ns/1ps
package deadlock_mon_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    COUNT   = 3'b010,
    BLOCKED = 3'b100
  } stall_st_e;

  localparam int DEF_THRESH = 16;
  localparam int DEF_EVT_W  = 16;

endpackage

// File: rtl/axis_stall_detector_if.sv
// Monitor-side bundle: the kernel's blocking/idle flags in, the stall report out.
`timescale 1ns/1ps
interface axis_stall_detector_if #(
  parameter int NUM_PORTS = 2,
  parameter int CNT_W     = 5,
  parameter int EVT_W     = 16
);
  logic [NUM_PORTS-1:0] port_blk_n;
  logic                 inst_idle;
  logic                 clear;
  logic                 block;
  logic [NUM_PORTS-1:0] block_ports;
  logic [CNT_W-1:0]     stall_cnt;
  logic [EVT_W-1:0]     event_cnt;

  modport master (
    output port_blk_n, inst_idle, clear,
    input  block, block_ports, stall_cnt, event_cnt
  );

  modport slave (
    input  port_blk_n, inst_idle, clear,
    output block, block_ports, stall_cnt, event_cnt
  );
endinterface

// File: rtl/axis_stall_detector_sat_counter.sv
// Width-parameterised saturating up-counter with synchronous clear.
// Clear wins over increment; the count parks at all-ones and never wraps.
`timescale 1ns/1ps
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (inc && !(&cnt))   cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/axis_stall_detector.sv
// Declares a deadlock when the same non-empty set of AXIS ports stays blocked
// for THRESH consecutive non-idle cycles; sticky until clear.
`timescale 1ns/1ps
module axis_stall_detector
  import deadlock_mon_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int THRESH    = DEF_THRESH,
  parameter int CNT_W     = $clog2(THRESH) + 1,
  parameter int EVT_W     = DEF_EVT_W
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  axis_stall_detector_if.slave mon
);

  stall_st_e            state, state_nxt;
  logic [NUM_PORTS-1:0] run_vec, run_nxt;
  logic [NUM_PORTS-1:0] snap, snap_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [NUM_PORTS-1:0] blk_vec;
  logic                 stall_now, same_vec, at_thresh, detect;

  assign blk_vec   = ~mon.port_blk_n;
  assign stall_now = (|blk_vec) && !mon.inst_idle;
  assign same_vec  = (blk_vec == run_vec);
  assign at_thresh = (cnt == CNT_W'(THRESH - 1));

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state   <= IDLE;
      run_vec <= '0;
      snap    <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      run_vec <= run_nxt;
      snap    <= snap_nxt;
      cnt     <= cnt_nxt;
    end
  end

  // clear is tested first everywhere so it beats a same-cycle detection
  always_comb begin
    state_nxt = state;
    run_nxt   = run_vec;
    snap_nxt  = snap;
    cnt_nxt   = cnt;
    detect    = 1'b0;
    unique case (state)
      IDLE: begin
        if (stall_now && !mon.clear) begin
          state_nxt = COUNT;
          cnt_nxt   = CNT_W'(1);
          run_nxt   = blk_vec;
        end else begin
          cnt_nxt   = '0;
        end
      end
      COUNT: begin
        if (mon.clear || !stall_now) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (!same_vec) begin
          cnt_nxt   = CNT_W'(1);
          run_nxt   = blk_vec;
        end else if (at_thresh) begin
          state_nxt = BLOCKED;
          snap_nxt  = blk_vec;
          detect    = 1'b1;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      BLOCKED: begin
        if (mon.clear) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  sat_counter #(.W(EVT_W)) u_evt_cnt (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .clr   (1'b0),
    .inc   (detect),
    .cnt   (mon.event_cnt)
  );

  assign mon.block       = (state == BLOCKED);
  assign mon.block_ports = snap;
  assign mon.stall_cnt   = cnt;

endmodule

// File: doc/axis_stall_detector.md
# axis_stall_detector

Per-kernel stall detector feeding the kernel deadlock report logic. It watches the per-port AXIS blocking indicators of an HLS kernel (`*_TDATA_blk_n`) together with the kernel's idle flag. When the same non-empty set of ports stays blocked for `THRESH` consecutive cycles, it raises a sticky `block` flag and freezes a snapshot of the blocked ports. The report FSM and diagnosis dump downstream consume `block`, `block_ports` and `event_cnt`.

## Interface
Parameters:
- `NUM_PORTS`, default 2: number of monitored AXIS ports; ≥1.
- `THRESH`, default 16: consecutive stalled cycles before `block`; ≥2.
- `CNT_W`, default `$clog2(THRESH)+1`: width of the stall-run counter.
- `EVT_W`, default 16: width of the stall-event counter.

Ports:
- `ap_clk`, input, 1: clock.
- `ap_rst_n`, input, 1: reset, asynchronous, active-low.
- `port_blk_n`, input, NUM_PORTS: per-port blocking flags. 0 means the kernel is waiting on that port.
- `inst_idle`, input, 1: kernel is idle. While high, blocking is not counted as a stall.
- `clear`, input, 1: single-cycle pulse. Releases `block` and re-arms detection.
- `block`, output, 1: deadlock declared; sticky.
- `block_ports`, output, NUM_PORTS: frozen `~port_blk_n` vector captured at detection.
- `stall_cnt`, output, CNT_W: current stall-run length.
- `event_cnt`, output, EVT_W: number of `block` assertions since reset; saturating.

## Operation
- Definitions:
  - `blk_vec = ~port_blk_n`
  - `stall_now = (blk_vec != 0) && !inst_idle`
- Registered state: `run_vec` (the vector being timed) and the FSM state, one of IDLE, COUNT, BLOCKED.
- IDLE:
  - If `stall_now` and not `clear`: go to COUNT, `stall_cnt` ← 1, `run_vec` ← `blk_vec`.
  - Otherwise stay; `stall_cnt` = 0.
- COUNT:
  - `clear`: go to IDLE, `stall_cnt` ← 0.
  - `!stall_now`: go to IDLE, `stall_cnt` ← 0.
  - `stall_now` and `blk_vec != run_vec`: restart the run. Stay in COUNT, `stall_cnt` ← 1, `run_vec` ← `blk_vec`.
  - `stall_now`, `blk_vec == run_vec`, `stall_cnt == THRESH-1`:
    - go to BLOCKED;
    - `block_ports` ← `blk_vec`;
    - `event_cnt` += 1, saturating at all-ones;
    - `stall_cnt` holds.
  - Otherwise: `stall_cnt` += 1.
- BLOCKED:
  - `block` = 1. `block_ports` and `stall_cnt` are frozen regardless of inputs.
  - Only `clear` exits, to IDLE with `stall_cnt` ← 0. `block_ports` keeps its last value until the next detection.
- `clear` always has priority over every stall event in the same cycle.
- `block` is decoded from state BLOCKED. It is glitch-free because the state is registered.

## Timing
- Values during reset (`ap_rst_n` = 0), held until first update:
  - state = IDLE
  - `block` = 0
  - `block_ports` = 0
  - `stall_cnt` = 0
  - `event_cnt` = 0
  - `run_vec` = 0
- Reset asserted at any point, including mid-COUNT or in BLOCKED, forces all of the above immediately, asynchronously.
- Detection latency:
  - Let `stall_now` be high with a constant `blk_vec` in cycles 0 … THRESH-1.
  - `stall_cnt` reads k in cycle k, for k = 1 … THRESH-1.
  - `block` is high from cycle THRESH onward.
- A single cycle with `stall_now` = 0 or a changed vector restarts the full THRESH window.
- `clear` sampled in cycle n gives `block` = 0 in cycle n+1. The earliest re-detection is cycle n+1+THRESH.
- `inst_idle` high masks stalls in the same cycle; no pipeline delay.
- `event_cnt` at all-ones stays all-ones; it never wraps.

## Structure
- Shared package `deadlock_mon_pkg`:
  - state enum `stall_st_e` {IDLE, COUNT, BLOCKED}, one-hot encoded;
  - default `THRESH`;
  - default `EVT_W`.
- One natural sub-module: `sat_counter`, a parameterised width, increment-enable, saturating counter with synchronous clear. Used for `event_cnt`; the downstream report block reuses it.
- Everything else stays inline: FSM, `run_vec` compare, snapshot register.

## Test plan
- NUM_PORTS=2, THRESH=16: `port_blk_n`=2'b10 held, `inst_idle`=0 → `stall_cnt` ramps 1…15; `block`=1 at cycle 16; `block_ports`=2'b01; `event_cnt`=1.
- Same stimulus but `port_blk_n` goes to 2'b11 at cycle 9 for one cycle → `stall_cnt` drops to 0; `block` only 16 cycles after the stall resumes.
- Vector changes from 2'b01 to 2'b11 at cycle 5, then holds → counter restarts at 1; `block` at cycle 21; `block_ports`=2'b11.
- `inst_idle`=1 with both ports blocked for 100 cycles → `block` stays 0; `stall_cnt` stays 0.
- In BLOCKED: pulse `clear` while stall persists → `block` drops the next cycle and re-asserts 16 cycles later; `event_cnt`=2. `clear` in the same cycle as detection → stays IDLE and `event_cnt` is unchanged.
- Deassert `ap_rst_n` mid-COUNT (`stall_cnt`=7) and in BLOCKED → all outputs 0 immediately, without waiting for a clock edge; EVT_W=2 with 5 detections → `event_cnt` saturates at 3.
